// File: rtl/frame_grabber_if.sv
// Capture-side sync/pixel inputs and dump-side byte handshake of the frame grabber.
interface frame_grabber_if #(parameter int PIX_W = 16);
  logic             arm, abort;
  logic             frame_start, frame_end, line_start, line_end;
  logic             pix_valid;
  logic [PIX_W-1:0] pix_data;
  logic [7:0]       out_byte;
  logic             out_valid, out_ready;
  logic             busy, done, short_frame, overrun;

  modport master (
    output arm, abort, frame_start, frame_end, line_start, line_end,
           pix_valid, pix_data, out_ready,
    input  out_byte, out_valid, busy, done, short_frame, overrun
  );
  modport slave (
    input  arm, abort, frame_start, frame_end, line_start, line_end,
           pix_valid, pix_data, out_ready,
    output out_byte, out_valid, busy, done, short_frame, overrun
  );
endinterface

// File: rtl/frame_grabber.sv
// Arm-triggered single-frame capture into block RAM with optional decimation,
// then byte-serial dump (header + raster pixels, LSB first) over valid/ready.
module frame_grabber #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int PIX_W      = 16,
  parameter int DECIM_LOG2 = 0,
  parameter int HEADER_EN  = 1
) (
  input logic             clk,
  input logic             resetn,
  frame_grabber_if.slave  bus
);
  localparam int W     = H_ACTIVE >> DECIM_LOG2;
  localparam int H     = V_ACTIVE >> DECIM_LOG2;
  localparam int DEPTH = W * H;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BPP   = PIX_W / 8;
  localparam int BSW   = (BPP > 1) ? $clog2(BPP) : 1;
  localparam int XW    = $clog2(H_ACTIVE + 1);
  localparam int YW    = $clog2(V_ACTIVE + 1);
  localparam logic [XW-1:0]  X_MAX  = XW'(H_ACTIVE);
  localparam logic [YW-1:0]  Y_MAX  = YW'(V_ACTIVE);
  localparam logic [XW-1:0]  X_MSK  = XW'((1 << DECIM_LOG2) - 1);
  localparam logic [YW-1:0]  Y_MSK  = YW'((1 << DECIM_LOG2) - 1);
  localparam logic [AW-1:0]  W_A    = AW'(W);
  localparam logic [AW-1:0]  LAST_A = AW'(DEPTH - 1);
  localparam logic [BSW-1:0] LAST_B = BSW'(BPP - 1);
  localparam logic [15:0]    W16    = 16'(W);
  localparam logic [15:0]    H16    = 16'(H);
  localparam logic [2:0]     HDR_0  = (HEADER_EN != 0) ? 3'd0 : 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAP, S_DUMP} state_t;

  state_t           state_q, state_d;
  logic [XW-1:0]    x_q, x_d, x_eff;
  logic [YW-1:0]    y_q, y_d, y_eff, y_inc;
  logic [AW-1:0]    base_q, base_d, base_eff;
  logic             wr_en_q, wr_en_d;
  logic [AW-1:0]    wr_addr_q, wr_addr_d;
  logic [PIX_W-1:0] wr_data_q, wr_data_d;
  logic [AW-1:0]    pa_q, pa_d;
  logic [BSW-1:0]   bsel_q, bsel_d;
  logic [2:0]       hdr_q, hdr_d;
  logic             src_end_q, src_end_d;
  logic [7:0]       out_byte_q, out_byte_d, src_byte;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             short_q, short_d, ovr_q, ovr_d;
  logic             xfer, load;

  logic [PIX_W-1:0] ram [DEPTH];
  logic [PIX_W-1:0] mem_q;

  // Read address follows the byte pointer's next value, so mem_q always
  // holds the word of the byte about to be loaded: 1 byte/cycle, no FIFO.
  always_ff @(posedge clk) begin
    if (wr_en_q) ram[wr_addr_q] <= wr_data_q;
    mem_q <= ram[pa_d];
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    base_d      = base_q;
    x_eff       = x_q;
    y_eff       = y_q;
    y_inc       = y_q;
    base_eff    = base_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    pa_d        = pa_q;
    bsel_d      = bsel_q;
    hdr_d       = hdr_q;
    src_end_d   = src_end_q;
    out_byte_d  = out_byte_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    short_d     = short_q;
    ovr_d       = ovr_q;

    case (hdr_q)
      3'd0:    src_byte = 8'hA5;
      3'd1:    src_byte = 8'h5A;
      3'd2:    src_byte = W16[7:0];
      3'd3:    src_byte = W16[15:8];
      3'd4:    src_byte = H16[7:0];
      3'd5:    src_byte = H16[15:8];
      default: src_byte = mem_q[8*bsel_q +: 8];
    endcase

    xfer = out_valid_q & bus.out_ready;
    load = (state_q == S_DUMP) && !src_end_q && (!out_valid_q || bus.out_ready);

    case (state_q)
      S_IDLE: if (bus.arm) begin
        state_d = S_ARMED;
        short_d = 1'b0;
        ovr_d   = 1'b0;
      end
      S_ARMED: if (bus.frame_start) begin
        state_d = S_CAP;
        x_d     = '0;
        y_d     = '0;
        base_d  = '0;
      end
      S_CAP: begin
        x_eff    = (bus.frame_start || bus.line_start) ? '0 : x_q;
        y_eff    = bus.frame_start ? '0 : y_q;
        base_eff = bus.frame_start ? '0 : base_q;
        y_inc    = y_eff + YW'(1);
        if (bus.pix_valid) begin
          if (x_eff < X_MAX && y_eff < Y_MAX) begin
            if ((x_eff & X_MSK) == '0 && (y_eff & Y_MSK) == '0) begin
              wr_en_d   = 1'b1;
              wr_addr_d = base_eff + AW'(x_eff >> DECIM_LOG2);
              wr_data_d = bus.pix_data;
            end
          end else begin
            ovr_d = 1'b1;
          end
        end
        // Counters saturate at the active size; anything past it is overrun.
        x_d    = (bus.pix_valid && x_eff != X_MAX) ? x_eff + XW'(1) : x_eff;
        y_d    = y_eff;
        base_d = base_eff;
        if (bus.line_end && y_eff != Y_MAX) begin
          y_d = y_inc;
          if ((y_inc & Y_MSK) == '0) base_d = base_eff + W_A;
        end
        if (bus.frame_end) begin
          state_d = S_DUMP;
          if (y_d != Y_MAX) short_d = 1'b1;
        end
      end
      default: ;
    endcase

    if (state_q != S_DUMP) begin
      pa_d      = '0;
      bsel_d    = '0;
      hdr_d     = HDR_0;
      src_end_d = 1'b0;
    end

    if (xfer) out_valid_d = 1'b0;
    if (load) begin
      out_valid_d = 1'b1;
      out_byte_d  = src_byte;
      if (hdr_q != 3'd6) begin
        hdr_d = hdr_q + 3'd1;
      end else if (bsel_q == LAST_B) begin
        bsel_d = '0;
        if (pa_q == LAST_A) src_end_d = 1'b1;
        else                pa_d      = pa_q + AW'(1);
      end else begin
        bsel_d = bsel_q + BSW'(1);
      end
    end
    if (state_q == S_DUMP && xfer && src_end_q) begin
      state_d = S_IDLE;
      done_d  = 1'b1;
    end

    if (bus.abort) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
      wr_en_d     = 1'b0;
      done_d      = 1'b0;
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      base_q      <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      pa_q        <= '0;
      bsel_q      <= '0;
      hdr_q       <= HDR_0;
      src_end_q   <= 1'b0;
      out_byte_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      short_q     <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      base_q      <= base_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      pa_q        <= pa_d;
      bsel_q      <= bsel_d;
      hdr_q       <= hdr_d;
      src_end_q   <= src_end_d;
      out_byte_q  <= out_byte_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      short_q     <= short_d;
      ovr_q       <= ovr_d;
    end
  end

  assign bus.out_byte    = out_byte_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.short_frame = short_q;
  assign bus.overrun     = ovr_q;
endmodule
